// File: rtl/mmse_frame_sequencer_pkg.sv
// Shared types and constants for the MMSE frame sequencer.
// Holds the data word width, the H/N and y word counts, the Q8.8 unity value
// and the sequencer state encoding.
package mmse_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned H_WORDS = 16;
    localparam int unsigned Y_WORDS = 8;
    localparam int unsigned H_BITS  = H_WORDS * DATA_W;
    localparam int unsigned Y_BITS  = Y_WORDS * DATA_W;

    // Q8.8 representation of 1.0
    localparam logic [DATA_W-1:0] ONE = 16'h0100;

    typedef logic [H_BITS-1:0] h_mat_t;
    typedef logic [Y_BITS-1:0] y_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_Y  = 3'd1,
        ST_RUN     = 3'd2,
        ST_OUT     = 3'd3,
        ST_RELEASE = 3'd4
    } mmse_seq_state_t;

endpackage

// File: rtl/mmse_frame_sequencer_if.sv
// Bundle of all sequencer-facing signals: configuration input, y input stream,
// detector start/finish handshake, x output stream and status.
// master : frame front-end / detector / demapper side
// slave  : the sequencer itself
interface mmse_frame_sequencer_if
    import mmse_pkg::*;
;
    logic   cfg_valid;
    logic   cfg_ready;
    h_mat_t cfg_h;
    h_mat_t cfg_n;
    logic   y_valid;
    logic   y_ready;
    y_vec_t y_data;
    logic   det_start;
    logic   det_finish;
    h_mat_t det_h;
    h_mat_t det_n;
    y_vec_t det_y;
    y_vec_t det_x;
    logic   x_valid;
    logic   x_ready;
    y_vec_t x_data;
    logic   x_last;
    logic   busy;
    logic   err_timeout;
    logic [7:0] sym_cnt;

    modport master (
        output cfg_valid, cfg_h, cfg_n, y_valid, y_data, det_finish, det_x, x_ready,
        input  cfg_ready, y_ready, det_start, det_h, det_n, det_y,
               x_valid, x_data, x_last, busy, err_timeout, sym_cnt
    );

    modport slave (
        input  cfg_valid, cfg_h, cfg_n, y_valid, y_data, det_finish, det_x, x_ready,
        output cfg_ready, y_ready, det_start, det_h, det_n, det_y,
               x_valid, x_data, x_last, busy, err_timeout, sym_cnt
    );

endinterface

// File: rtl/mmse_frame_sequencer_watchdog.sv
// Saturating 16-bit handshake watchdog.
// Ports: clk, reset (async high), clear, enable,
//        expired_c (count >= TIMEOUT), reach_c (count hits TIMEOUT at this edge).
module mmse_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c,
    output logic reach_c
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] count;

    // Count while enabled, hold at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && (count < LIMIT)) begin
            count <= count + 16'd1;
        end
    end

    assign expired_c = (count >= LIMIT);
    // Lets the controller leave on the same edge the count arrives at the limit
    assign reach_c   = enable && (count >= (LIMIT - 16'd1));

endmodule

// File: rtl/mmse_frame_sequencer.sv
// Sequences one 2x2 MMSE detector over a block of N_SYM y vectors that share
// one H/N configuration. Pure pass/capture of data words, no arithmetic.
// Ports: clk, reset (async high), bus (slave side of mmse_frame_sequencer_if:
//        cfg in, y in, detector handshake, x out, busy/err_timeout/sym_cnt).
module mmse_frame_sequencer
    import mmse_pkg::*;
#(
    parameter int unsigned N_SYM   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mmse_frame_sequencer_if.slave bus
);

    localparam logic [7:0] LAST_IDX = 8'(N_SYM - 1);

    mmse_seq_state_t state, state_next;

    logic   cfg_ready, y_ready, det_start, x_valid, busy;
    logic   x_last, err_timeout;
    logic [7:0] sym_cnt;
    h_mat_t det_h, det_n;
    y_vec_t det_y, x_data;

    logic cfg_take, y_take, x_cap, x_take, err_set, sym_inc;
    logic wd_en, wd_clr, wd_expired_c, wd_reach_c, wd_hit;
    logic at_last;

    assign at_last = (sym_cnt == LAST_IDX);
    assign wd_hit  = wd_reach_c || (wd_en && wd_expired_c);

    mmse_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk       (clk),
        .reset     (reset),
        .clear     (wd_clr),
        .enable    (wd_en),
        .expired_c (wd_expired_c),
        .reach_c   (wd_reach_c)
    );

    // State register and state-decoded handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            y_ready   <= 1'b0;
            det_start <= 1'b0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_ready <= (state_next == ST_IDLE);
            y_ready   <= (state_next == ST_WAIT_Y);
            det_start <= (state_next == ST_RUN);
            x_valid   <= (state_next == ST_OUT);
            busy      <= (state_next != ST_IDLE);
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        cfg_take   = 1'b0;
        y_take     = 1'b0;
        x_cap      = 1'b0;
        x_take     = 1'b0;
        err_set    = 1'b0;
        sym_inc    = 1'b0;
        wd_en      = 1'b0;
        wd_clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    cfg_take   = 1'b1;
                    state_next = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                if (bus.y_valid) begin
                    y_take     = 1'b1;
                    wd_clr     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_en = 1'b1;
                // finish beats a coincident timeout
                if (bus.det_finish) begin
                    x_cap      = 1'b1;
                    state_next = ST_OUT;
                end else if (wd_hit) begin
                    err_set    = 1'b1;
                    state_next = ST_RELEASE;
                end
            end
            ST_OUT: begin
                if (bus.x_ready) begin
                    x_take     = 1'b1;
                    wd_clr     = 1'b1;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                wd_en = 1'b1;
                if (!bus.det_finish) begin
                    if (err_timeout || at_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        sym_inc    = 1'b1;
                        state_next = ST_WAIT_Y;
                    end
                end else if (wd_hit) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data capture, block counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_h       <= '0;
            det_n       <= '0;
            det_y       <= '0;
            x_data      <= '0;
            x_last      <= 1'b0;
            err_timeout <= 1'b0;
            sym_cnt     <= 8'd0;
        end else begin
            if (cfg_take) begin
                det_h       <= bus.cfg_h;
                det_n       <= bus.cfg_n;
                sym_cnt     <= 8'd0;
                err_timeout <= 1'b0;
            end
            if (y_take) begin
                det_y <= bus.y_data;
            end
            if (x_cap) begin
                x_data <= bus.det_x;
                x_last <= at_last;
            end else if (x_take) begin
                x_last <= 1'b0;
            end
            if (err_set) begin
                err_timeout <= 1'b1;
            end
            if (sym_inc) begin
                sym_cnt <= sym_cnt + 8'd1;
            end
        end
    end

    assign bus.cfg_ready   = cfg_ready;
    assign bus.y_ready     = y_ready;
    assign bus.det_start   = det_start;
    assign bus.det_h       = det_h;
    assign bus.det_n       = det_n;
    assign bus.det_y       = det_y;
    assign bus.x_valid     = x_valid;
    assign bus.x_data      = x_data;
    assign bus.x_last      = x_last;
    assign bus.busy        = busy;
    assign bus.err_timeout = err_timeout;
    assign bus.sym_cnt     = sym_cnt;

endmodule

// File: tb/tb_mmse_frame_sequencer.sv
// Testbench for mmse_frame_sequencer (N_SYM=2, TIMEOUT=30) with a behavioural
// detector stub and a queue-based scoreboard on the x output stream.
module tb_mmse_frame_sequencer;
    import mmse_pkg::*;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    typedef struct packed {
        y_vec_t data;
        logic   last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = M_NORMAL;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_xfer = 0;
    int   lat = 0;
    exp_t q[$];

    mmse_frame_sequencer_if bus();

    mmse_frame_sequencer #(.N_SYM(2), .TIMEOUT(30)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Detector stub: 20-cycle latency, x = y, finish held until start drops
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.det_finish <= 1'b0;
            bus.det_x      <= '0;
            lat            <= 0;
        end else if (bus.det_start && !bus.det_finish && mode != M_NEVER) begin
            if (lat == 19) begin
                bus.det_finish <= 1'b1;
                bus.det_x      <= bus.det_y;
                lat            <= 0;
            end else begin
                lat <= lat + 1;
            end
        end else if (!bus.det_start && mode != M_STUCK) begin
            bus.det_finish <= 1'b0;
            lat            <= 0;
        end
    end

    // Monitor: every x transfer is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.x_valid && bus.x_ready) begin
            exp_t e;
            n_xfer = n_xfer + 1;
            n_cmp  = n_cmp + 1;
            if (q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL x_unexpected: got data=%h last=%b, none required", bus.x_data, bus.x_last);
            end else begin
                e = q.pop_front();
                if (bus.x_data !== e.data || bus.x_last !== e.last) begin
                    n_err = n_err + 1;
                    $display("FAIL x_transfer: got data=%h last=%b, required data=%h last=%b",
                             bus.x_data, bus.x_last, e.data, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send_cfg(input h_mat_t h, input h_mat_t n);
        int k = 0;
        while (!bus.cfg_ready && k < 300) begin tick(); k++; end
        if (k >= 300) bound_fail("cfg_ready_wait");
        bus.cfg_valid = 1'b1;
        bus.cfg_h     = h;
        bus.cfg_n     = n;
        tick();
        bus.cfg_valid = 1'b0;
        chk1("cfg_ready_after_cfg", bus.cfg_ready, 1'b0);
        chk1("y_ready_after_cfg", bus.y_ready, 1'b1);
        chkv("det_h", 256'(bus.det_h), 256'(h));
        chkv("det_n", 256'(bus.det_n), 256'(n));
        chk1("err_cleared_by_cfg", bus.err_timeout, 1'b0);
    endtask

    task automatic send_y(input y_vec_t y, input logic last, input logic push);
        int k = 0;
        exp_t e;
        while (!bus.y_ready && k < 300) begin tick(); k++; end
        if (k >= 300) bound_fail("y_ready_wait");
        if (push) begin
            e.data = y;
            e.last = last;
            q.push_back(e);
        end
        bus.y_valid = 1'b1;
        bus.y_data  = y;
        tick();
        bus.y_valid = 1'b0;
        chk1("det_start_after_y", bus.det_start, 1'b1);
        chkv("det_y", 256'(bus.det_y), 256'(y));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!bus.cfg_ready && k < 300) begin tick(); k++; end
        if (k >= 300) bound_fail(name);
        chk1("busy_idle", bus.busy, 1'b0);
    endtask

    h_mat_t h_ref, n_ref, h2;
    y_vec_t y_a, y_b, y_c, y_d, y_e, y_f, y_g;

    initial begin
        int k;
        h_ref = {16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000,
                 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hFFE7, 16'h0033, 16'h0019, 16'h0100};
        n_ref = {16{16'h0010}};
        h2    = {16{16'h0100}};
        y_a = {16'h0033, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0019};
        y_b = {16'h0033, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0019};
        y_c = {8{16'hA5A5}};
        y_d = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0100, 16'hFF00, 16'h00FF, 16'h1234};
        y_e = {8{16'h0042}};
        y_f = {16'hBEEF, 16'hCAFE, 16'hF00D, 16'hD00D, 16'h0BAD, 16'hC0DE, 16'hFACE, 16'hFEED};
        y_g = {8{16'h5A5A}};

        bus.cfg_valid  = 1'b0;
        bus.cfg_h      = '0;
        bus.cfg_n      = '0;
        bus.y_valid    = 1'b0;
        bus.y_data     = '0;
        bus.x_ready    = 1'b0;

        repeat (3) tick();
        // Reset state
        chk1("rst_cfg_ready", bus.cfg_ready, 1'b1);
        chk1("rst_y_ready", bus.y_ready, 1'b0);
        chk1("rst_det_start", bus.det_start, 1'b0);
        chk1("rst_x_valid", bus.x_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_err", bus.err_timeout, 1'b0);
        chkv("rst_sym_cnt", 256'(bus.sym_cnt), 256'(0));
        chkv("rst_det_h", 256'(bus.det_h), 256'(0));
        chkv("rst_x_data", 256'(bus.x_data), 256'(0));
        rst = 1'b0;
        tick();

        // Two-vector block, downstream always ready
        bus.x_ready = 1'b1;
        send_cfg(h_ref, n_ref);
        chk1("busy_in_block", bus.busy, 1'b1);
        send_y(y_a, 1'b0, 1'b1);
        send_y(y_b, 1'b1, 1'b1);
        wait_idle("idle_after_block1");
        chkv("xfers_block1", 256'(n_xfer), 256'(2));

        // Backpressure on x
        bus.x_ready = 1'b0;
        send_cfg(h2, n_ref);
        send_y(y_c, 1'b0, 1'b1);
        k = 0;
        while (!bus.x_valid && k < 100) begin tick(); k++; end
        if (k >= 100) bound_fail("x_valid_wait");
        for (int i = 0; i < 10; i++) begin
            chkv("x_data_stable", 256'(bus.x_data), 256'(y_c));
            chk1("x_last_stable", bus.x_last, 1'b0);
            chk1("x_valid_held", bus.x_valid, 1'b1);
            chk1("det_start_low_out", bus.det_start, 1'b0);
            chk1("no_y_ready_in_out", bus.y_ready, 1'b0);
            tick();
        end
        bus.x_ready = 1'b1;
        tick();
        chk1("no_y_ready_in_release", bus.y_ready, 1'b0);
        chkv("sym_cnt_before_inc", 256'(bus.sym_cnt), 256'(0));
        send_y(y_d, 1'b1, 1'b1);
        chkv("sym_cnt_second", 256'(bus.sym_cnt), 256'(1));
        wait_idle("idle_after_block2");

        // Detector never finishes: RUN watchdog
        mode = M_NEVER;
        send_cfg(h_ref, n_ref);
        send_y(y_e, 1'b0, 1'b0);
        k = 0;
        while (bus.det_start && k < 200) begin tick(); k++; end
        chkv("det_start_cycles", 256'(k), 256'(30));
        chk1("err_after_run_timeout", bus.err_timeout, 1'b1);
        wait_idle("idle_after_run_timeout");
        chk1("err_sticky_idle", bus.err_timeout, 1'b1);

        // Detector holds finish: RELEASE watchdog
        mode = M_NORMAL;
        send_cfg(h2, n_ref);
        mode = M_STUCK;
        send_y(y_f, 1'b0, 1'b1);
        wait_idle("idle_after_release_timeout");
        chk1("err_after_release_timeout", bus.err_timeout, 1'b1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.det_start) k++;
            tick();
        end
        chkv("no_det_start_after_err", 256'(k), 256'(0));
        mode = M_NORMAL;
        repeat (2) tick();

        // Asynchronous reset while in RUN
        send_cfg(h_ref, n_ref);
        send_y(y_g, 1'b0, 1'b0);
        repeat (5) tick();
        chk1("det_start_in_run", bus.det_start, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rst_async_det_start", bus.det_start, 1'b0);
        chk1("rst_async_x_valid", bus.x_valid, 1'b0);
        chk1("rst_async_cfg_ready", bus.cfg_ready, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk1("post_rst_cfg_ready", bus.cfg_ready, 1'b1);
        chkv("post_rst_sym_cnt", 256'(bus.sym_cnt), 256'(0));
        chk1("post_rst_busy", bus.busy, 1'b0);

        repeat (3) tick();
        chkv("scoreboard_empty", 256'(q.size()), 256'(0));
        chkv("xfers_total", 256'(n_xfer), 256'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation ran past its time limit");
        $fatal(1);
    end

endmodule
